// File: rtl/packet_pkg.sv
// Shared types for the switch egress path: port index/mask types, the arbiter
// FSM encoding and a reference round-robin pick for the default port count.
package packet_pkg;

    localparam int NUM_PORTS_DEF = 4;
    localparam int PORT_IDX_W    = $clog2(NUM_PORTS_DEF);

    typedef logic [PORT_IDX_W-1:0]    port_idx_t;
    typedef logic [NUM_PORTS_DEF-1:0] port_mask_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic      found;
        port_idx_t idx;
    } rr_pick_t;

    // Scan from the highest offset down so the nearest set bit at or above ptr wins last.
    function automatic rr_pick_t rr_pick(input port_mask_t mask, input port_idx_t ptr);
        rr_pick_t  res;
        port_idx_t cand;
        res = '0;
        for (int k = NUM_PORTS_DEF - 1; k >= 0; k--) begin
            cand = ptr + port_idx_t'(k);
            if (mask[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/switch_out_arbiter_rr_core.sv
// Combinational round-robin picker: first set bit of elig at or above ptr,
// wrapping modulo NUM_PORTS.
module rr_arbiter_core
    import packet_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF
) (
    input  logic [NUM_PORTS-1:0]         elig,
    input  logic [$clog2(NUM_PORTS)-1:0] ptr,
    output logic [$clog2(NUM_PORTS)-1:0] winner,
    output logic                         found
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS == NUM_PORTS_DEF) begin : g_default
        rr_pick_t pick;

        assign pick   = rr_pick(elig, ptr);
        assign winner = pick.idx;
        assign found  = pick.found;
    end else begin : g_generic
        // rot[k] is the requester k positions above ptr, so a plain priority
        // encoder on rot yields the round-robin offset.
        logic [NUM_PORTS-1:0] rot;
        logic [IDX_W-1:0]     offset;
        logic                 any;

        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            logic [IDX_W-1:0] src;
            assign src     = IDX_W'(gi) + ptr;
            assign rot[gi] = elig[src];
        end

        always_comb begin
            any    = 1'b0;
            offset = '0;
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                if (rot[k]) begin
                    any    = 1'b1;
                    offset = IDX_W'(k);
                end
            end
        end

        assign winner = ptr + offset;
        assign found  = any;
    end

endmodule

// File: rtl/switch_out_arbiter.sv
// Per-egress-port scheduler: round-robin pick among ingress queues, pop the
// winner and hold its packet in a valid/ready output register.
module switch_out_arbiter
    import packet_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int PORT_ID   = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_valid,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  req_source,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]     req_data,
    output logic [NUM_PORTS-1:0]                 req_ack,
    input  logic [NUM_PORTS-1:0]                 cfg_mask,
    output logic                                 out_valid,
    output logic [NUM_PORTS-1:0]                 out_source,
    output logic [DATA_W-1:0]                    out_data,
    output logic [$clog2(NUM_PORTS)-1:0]         out_grant,
    input  logic                                 out_ready,
    output logic [$clog2(NUM_PORTS)-1:0]         rr_ptr
);

    localparam int IDX_W = $clog2(NUM_PORTS);

    if (NUM_PORTS < 2 || (NUM_PORTS & (NUM_PORTS - 1)) != 0) begin : g_bad_num_ports
        $error("switch_out_arbiter: NUM_PORTS must be a power of two >= 2");
    end
    if (PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_bad_port_id
        $error("switch_out_arbiter: PORT_ID out of range");
    end

    arb_state_e            state_q, state_d;
    logic [NUM_PORTS-1:0]  out_source_q, out_source_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_grant_q, out_grant_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0]  elig;
    logic [IDX_W-1:0]      winner;
    logic                  found;
    logic                  load;

    assign elig = req_valid & ~cfg_mask;

    rr_arbiter_core #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_core (
        .elig   (elig),
        .ptr    (rr_ptr_q),
        .winner (winner),
        .found  (found)
    );

    // A pop is only legal when the register is free or being emptied this cycle.
    assign load = found && (state_q == ST_IDLE || out_ready) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_source_q <= '0;
            out_data_q   <= '0;
            out_grant_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_source_q <= out_source_d;
            out_data_q   <= out_data_d;
            out_grant_q  <= out_grant_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load) state_d = ST_HOLD;
            ST_HOLD: if (out_ready && !load) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_source_d = out_source_q;
        out_data_d   = out_data_q;
        out_grant_d  = out_grant_q;
        rr_ptr_d     = rr_ptr_q;
        if (load) begin
            out_source_d = req_source[winner];
            out_data_d   = req_data[winner];
            out_grant_d  = winner;
            rr_ptr_d     = winner + IDX_W'(1);
        end
    end

    always_comb begin
        req_ack = '0;
        if (load) req_ack[winner] = 1'b1;
        out_valid = (state_q == ST_HOLD);
    end

    assign out_source = out_source_q;
    assign out_data   = out_data_q;
    assign out_grant  = out_grant_q;
    assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Self-checking bench for switch_out_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_switch_out_arbiter;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0][N-1:0] req_source;
    logic [N-1:0][7:0]  req_data;
    logic [N-1:0]       req_ack;
    logic [N-1:0]       cfg_mask;
    logic               out_valid;
    logic [N-1:0]       out_source;
    logic [7:0]         out_data;
    logic [1:0]         out_grant;
    logic               out_ready;
    logic [1:0]         rr_ptr;

    int tests = 0;
    int fails = 0;

    bit       m_valid;
    logic [7:0] m_data;
    logic [N-1:0] m_src;
    int       m_grant;
    int       m_ptr;

    always #5 clk = ~clk;

    switch_out_arbiter #(.NUM_PORTS(N), .DATA_W(8), .PORT_ID(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_source (req_source),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .cfg_mask   (cfg_mask),
        .out_valid  (out_valid),
        .out_source (out_source),
        .out_data   (out_data),
        .out_grant  (out_grant),
        .out_ready  (out_ready),
        .rr_ptr     (rr_ptr)
    );

    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i] && !m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ack();
        int w;
        logic [N-1:0] a;
        w = pick(req_valid, cfg_mask, m_ptr);
        a = '0;
        if (!rst && w >= 0 && (!m_valid || out_ready)) a[w] = 1'b1;
        return a;
    endfunction

    task automatic tick();
        int w;
        bit ld;
        logic [7:0] cd;
        logic [N-1:0] cs;
        w  = pick(req_valid, cfg_mask, m_ptr);
        ld = !rst && (w >= 0) && (!m_valid || out_ready);
        cd = '0;
        cs = '0;
        if (w >= 0) begin
            cd = req_data[w];
            cs = req_source[w];
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_src = '0; m_grant = 0; m_ptr = 0;
        end else if (ld) begin
            m_valid = 1; m_data = cd; m_src = cs; m_grant = w; m_ptr = (w + 1) % N;
            $display("[TB] txn t=%0t grant=%0d data=%02h next_ptr=%0d", $time, w, cd, m_ptr);
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = '0; cfg_mask = '0; out_ready = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 4'b1111; cfg_mask = '0; out_ready = 1;
        for (int i = 0; i < N; i++) begin
            req_data[i] = 8'h50 + 8'(i);
            req_source[i] = 4'(1 << i);
        end
        #1;
        tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack got=%b exp=0000", req_ack); end
        tick(); tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        tests++; if (rr_ptr !== 2'd0) begin fails++; $display("FAIL reset_ptr got=%0d exp=0", rr_ptr); end
        tests++; if (out_data !== 8'h00 || out_grant !== 2'd0 || out_source !== 4'b0000) begin
            fails++; $display("FAIL reset_regs got data=%h grant=%0d src=%b exp 0/0/0", out_data, out_grant, out_source);
        end
        rst = 0; req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_data[0] = 8'hA1; out_ready = 1;
        #1;
        tests++; if (req_ack !== 4'b0001) begin fails++; $display("FAIL single_ack got=%b exp=0001", req_ack); end
        tick();
        req_valid = '0;
        tests++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
            fails++; $display("FAIL single_out got valid=%b data=%h exp 1/a1", out_valid, out_data);
        end
        tests++; if (out_grant !== 2'd0 || rr_ptr !== 2'd1) begin
            fails++; $display("FAIL single_grant got grant=%0d ptr=%0d exp 0/1", out_grant, rr_ptr);
        end
        tick();
    endtask

    task automatic test_full_contention();
        do_reset();
        req_valid = 4'b1111; out_ready = 1;
        for (int i = 0; i < N; i++) req_data[i] = 8'hD0 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (req_ack !== 4'(1 << (k % N))) begin
                fails++; $display("FAIL contention_ack[%0d] got=%b exp=%b", k, req_ack, 4'(1 << (k % N)));
            end
            tick();
            tests++; if (out_valid !== 1'b1 || out_grant !== 2'(k % N) || out_data !== 8'hD0 + 8'(k % N)) begin
                fails++; $display("FAIL contention_out[%0d] got valid=%b grant=%0d data=%h exp 1/%0d/%h",
                                  k, out_valid, out_grant, out_data, k % N, 8'hD0 + 8'(k % N));
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0100; req_data[2] = 8'hC2; out_ready = 1;
        tick();
        req_valid = 4'b1011; out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL bp_ack[%0d] got=%b exp=0000", k, req_ack); end
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== 8'hC2 || rr_ptr !== 2'd3) begin
                fails++; $display("FAIL bp_hold[%0d] got valid=%b data=%h ptr=%0d exp 1/c2/3", k, out_valid, out_data, rr_ptr);
            end
        end
        out_ready = 1;
        #1;
        tests++; if (req_ack !== 4'b1000) begin fails++; $display("FAIL bp_release_ack got=%b exp=1000", req_ack); end
        tick();
        tests++; if (out_grant !== 2'd3) begin fails++; $display("FAIL bp_grant3 got=%0d exp=3", out_grant); end
        tick();
        tests++; if (out_grant !== 2'd0) begin fails++; $display("FAIL bp_grant0 got=%0d exp=0", out_grant); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_mask_wrap();
        do_reset();
        req_valid = 4'b0100; out_ready = 1;
        tick();
        req_valid = 4'b1001; cfg_mask = 4'b1000;
        #1;
        tests++; if (req_ack !== 4'b0001) begin fails++; $display("FAIL mask_ack got=%b exp=0001", req_ack); end
        tick();
        tests++; if (out_grant !== 2'd0 || rr_ptr !== 2'd1) begin
            fails++; $display("FAIL mask_grant got grant=%0d ptr=%0d exp 0/1", out_grant, rr_ptr);
        end
        cfg_mask = '0;
        #1;
        tests++; if (req_ack !== 4'b1000) begin fails++; $display("FAIL unmask_ack got=%b exp=1000", req_ack); end
        tick();
        tests++; if (out_grant !== 2'd3 || rr_ptr !== 2'd0) begin
            fails++; $display("FAIL unmask_grant got grant=%0d ptr=%0d exp 3/0", out_grant, rr_ptr);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        req_valid = 4'b0010; out_ready = 1;
        tick();
        out_ready = 0; req_valid = 4'b1111; rst = 1;
        #1;
        tests++; if (req_ack !== 4'b0000) begin fails++; $display("FAIL rststall_ack got=%b exp=0000", req_ack); end
        tick();
        tests++; if (out_valid !== 1'b0 || rr_ptr !== 2'd0) begin
            fails++; $display("FAIL rststall_state got valid=%b ptr=%0d exp 0/0", out_valid, rr_ptr);
        end
        rst = 0; req_valid = 4'b0110; out_ready = 1;
        #1;
        tests++; if (req_ack !== 4'b0010) begin fails++; $display("FAIL rststall_first_ack got=%b exp=0010", req_ack); end
        tick();
        tests++; if (out_grant !== 2'd1) begin fails++; $display("FAIL rststall_grant got=%0d exp=1", out_grant); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        req_valid = 4'b0100; out_ready = 1;
        tick();
        req_valid = '0;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (out_valid !== 1'b0 || rr_ptr !== 2'd3) begin
                fails++; $display("FAIL drain_idle[%0d] got valid=%b ptr=%0d exp 0/3", k, out_valid, rr_ptr);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            req_valid = 4'($urandom);
            if ($urandom_range(0, 7) == 0) cfg_mask = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_data[i] = 8'($urandom);
                req_source[i] = 4'(1 << $urandom_range(0, N - 1));
            end
            #1;
            tests++; if (req_ack !== exp_ack()) begin
                fails++; $display("FAIL rand_ack[%0d] got=%b exp=%b", c, req_ack, exp_ack());
            end
            tick();
            tests++; if (out_valid !== m_valid || rr_ptr !== 2'(m_ptr)) begin
                fails++; $display("FAIL rand_state[%0d] got valid=%b ptr=%0d exp %b/%0d", c, out_valid, rr_ptr, m_valid, m_ptr);
            end
            if (m_valid) begin
                tests++; if (out_data !== m_data || out_grant !== 2'(m_grant) || out_source !== m_src) begin
                    fails++; $display("FAIL rand_payload[%0d] got data=%h grant=%0d src=%b exp %h/%0d/%b",
                                      c, out_data, out_grant, out_source, m_data, m_grant, m_src);
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; req_valid = '0; cfg_mask = '0; out_ready = 1;
        req_source = '0; req_data = '0;
        m_valid = 0; m_data = '0; m_src = '0; m_grant = 0; m_ptr = 0;
        test_reset();
        test_single();
        test_full_contention();
        test_backpressure();
        test_mask_wrap();
        test_reset_mid_stall();
        test_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
